// File: rtl/rom_loader.sv
// rom_loader: boot-time copy engine from registered ROM into instruction memory, holding the CPU in reset
module rom_loader #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32,
    parameter int LOAD_COUNT = 256,
    parameter bit AUTO_START = 1'b1
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_start,
    output logic [ADDR_WIDTH-1:0] o_rom_addr,
    input  logic [DATA_WIDTH-1:0] i_rom_data,
    output logic                  o_mem_we,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    output logic [DATA_WIDTH-1:0] o_mem_data,
    input  logic                  i_mem_ready,
    output logic                  o_cpu_reset,
    output logic                  o_busy,
    output logic                  o_done
);
    typedef enum logic [1:0] {S_IDLE, S_PRIME, S_COPY, S_DONE} state_t;
    localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(LOAD_COUNT - 1);
    state_t                r_state, w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_k, w_k_nxt, w_k_inc;
    assign w_k_inc     = r_k + ADDR_WIDTH'(1);
    assign o_mem_addr  = r_k;
    assign o_mem_data  = i_rom_data;
    assign o_cpu_reset = (r_state != S_DONE);
    assign o_busy      = (r_state == S_PRIME) || (r_state == S_COPY);
    assign o_done      = (r_state == S_DONE);
    // State and write-index registers; reset aborts any copy in progress
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= AUTO_START ? S_PRIME : S_IDLE;
            r_k     <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_k     <= w_k_nxt;
        end
    end
    // Next state, index update and ROM look-ahead address (k+1 when the current word is accepted)
    always_comb begin
        w_state_nxt = r_state;
        w_k_nxt     = r_k;
        o_mem_we    = 1'b0;
        o_rom_addr  = '0;
        case (r_state)
            S_IDLE:  w_state_nxt = i_start ? S_PRIME : S_IDLE;
            S_PRIME: begin
                w_state_nxt = S_COPY;
                w_k_nxt     = '0;
            end
            S_COPY: begin
                o_mem_we   = 1'b1;
                o_rom_addr = i_mem_ready ? w_k_inc : r_k;
                if (i_mem_ready) begin
                    w_k_nxt     = w_k_inc;
                    w_state_nxt = (r_k == LAST) ? S_DONE : S_COPY;
                end
            end
            S_DONE:  w_state_nxt = i_start ? S_PRIME : S_DONE;
            default: w_state_nxt = S_IDLE;
        endcase
    end
endmodule

// File: tb/tb_rom_loader.sv
// tb_rom_loader: directed checks of copy, stall, short image, manual start, start handling and reset abort
module tb_rom_loader;
    logic        clk = 1'b0;
    int          checks = 0;
    int          errors = 0;
    logic [31:0] img [256];

    always #5 clk = ~clk;

    function automatic logic [31:0] rom_val(input logic [7:0] a);
        case (a)
            8'h00:   rom_val = 32'h00000001;
            8'h02:   rom_val = 32'h20000040;
            8'h05:   rom_val = 32'h28820040;
            8'h06:   rom_val = 32'h0003fc03;
            8'h0d:   rom_val = 32'h20820381;
            8'h31:   rom_val = 32'h00000001;
            8'h32:   rom_val = 32'h00000000;
            default: rom_val = {a, ~a, a ^ 8'h5a, 8'hc3};
        endcase
    endfunction

    logic rst_a = 1'b1, st_a = 1'b0, rdy_a = 1'b1;
    logic we_a, cr_a, busy_a, done_a;
    logic [7:0] ra_a, ma_a;
    logic [31:0] rd_a, md_a;
    always @(posedge clk) rd_a <= rom_val(ra_a);
    rom_loader u_a (
        .i_clk(clk), .i_reset(rst_a), .i_start(st_a), .o_rom_addr(ra_a), .i_rom_data(rd_a),
        .o_mem_we(we_a), .o_mem_addr(ma_a), .o_mem_data(md_a), .i_mem_ready(rdy_a),
        .o_cpu_reset(cr_a), .o_busy(busy_a), .o_done(done_a)
    );

    logic rst_b = 1'b1, st_b = 1'b0, rdy_b = 1'b1;
    logic we_b, cr_b, busy_b, done_b;
    logic [7:0] ra_b, ma_b;
    logic [31:0] rd_b, md_b;
    always @(posedge clk) rd_b <= rom_val(ra_b);
    rom_loader #(.LOAD_COUNT(32'h32)) u_b (
        .i_clk(clk), .i_reset(rst_b), .i_start(st_b), .o_rom_addr(ra_b), .i_rom_data(rd_b),
        .o_mem_we(we_b), .o_mem_addr(ma_b), .o_mem_data(md_b), .i_mem_ready(rdy_b),
        .o_cpu_reset(cr_b), .o_busy(busy_b), .o_done(done_b)
    );

    logic rst_c = 1'b1, st_c = 1'b0, rdy_c = 1'b1;
    logic we_c, cr_c, busy_c, done_c;
    logic [7:0] ra_c, ma_c;
    logic [31:0] rd_c, md_c;
    always @(posedge clk) rd_c <= rom_val(ra_c);
    rom_loader #(.AUTO_START(1'b0)) u_c (
        .i_clk(clk), .i_reset(rst_c), .i_start(st_c), .o_rom_addr(ra_c), .i_rom_data(rd_c),
        .o_mem_we(we_c), .o_mem_addr(ma_c), .o_mem_data(md_c), .i_mem_ready(rdy_c),
        .o_cpu_reset(cr_c), .o_busy(busy_c), .o_done(done_c)
    );

    task automatic reset_a();
        rst_a = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst_a = 1'b0;
    endtask

    task automatic test_reset();
        rst_a = 1'b1;
        rdy_a = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (we_a !== 1'b0 || ma_a !== 8'h00 || cr_a !== 1'b1 || done_a !== 1'b0 || busy_a !== 1'b1 || ra_a !== 8'h00) begin
            errors++;
            $display("FAIL reset_values: we=%b addr=%h cpu_reset=%b done=%b busy=%b rom_addr=%h, need 0 00 1 0 1 00",
                     we_a, ma_a, cr_a, done_a, busy_a, ra_a);
        end
    endtask

    task automatic test_full_copy();
        rdy_a = 1'b1;
        reset_a();
        checks++;
        if (busy_a !== 1'b1 || we_a !== 1'b0 || ra_a !== 8'h00 || cr_a !== 1'b1) begin
            errors++;
            $display("FAIL full_prime: busy=%b we=%b rom_addr=%h cpu_reset=%b, need 1 0 00 1", busy_a, we_a, ra_a, cr_a);
        end
        for (int cyc = 1; cyc <= 256; cyc++) begin
            @(negedge clk);
            checks++;
            if (we_a !== 1'b1 || ma_a !== 8'(cyc - 1) || md_a !== rom_val(8'(cyc - 1)) || cr_a !== 1'b1 || done_a !== 1'b0) begin
                errors++;
                $display("FAIL full_write cycle %0d: we=%b addr=%h data=%h cpu_reset=%b, need 1 %h %h 1",
                         cyc, we_a, ma_a, md_a, cr_a, 8'(cyc - 1), rom_val(8'(cyc - 1)));
            end
            if (we_a === 1'b1) img[ma_a] = md_a;
        end
        @(negedge clk);
        checks++;
        if (done_a !== 1'b1 || cr_a !== 1'b0 || busy_a !== 1'b0 || we_a !== 1'b0) begin
            errors++;
            $display("FAIL full_done cycle 257: done=%b cpu_reset=%b busy=%b we=%b, need 1 0 0 0", done_a, cr_a, busy_a, we_a);
        end
        checks++;
        if (img[8'h02] !== 32'h20000040 || img[8'h0d] !== 32'h20820381 || img[8'h32] !== 32'h00000000) begin
            errors++;
            $display("FAIL full_spot: [02]=%h [0d]=%h [32]=%h, need 20000040 20820381 00000000",
                     img[8'h02], img[8'h0d], img[8'h32]);
        end
    endtask

    task automatic test_done_restart();
        int n = 0;
        int dcyc = -1;
        st_a = 1'b1;
        @(negedge clk);
        st_a = 1'b0;
        checks++;
        if (cr_a !== 1'b1 || done_a !== 1'b0 || busy_a !== 1'b1 || we_a !== 1'b0 || ra_a !== 8'h00) begin
            errors++;
            $display("FAIL restart_prime: cpu_reset=%b done=%b busy=%b we=%b rom_addr=%h, need 1 0 1 0 00",
                     cr_a, done_a, busy_a, we_a, ra_a);
        end
        for (int cyc = 1; cyc <= 300; cyc++) begin
            @(negedge clk);
            if (done_a === 1'b1) begin
                dcyc = cyc;
                break;
            end
            if (we_a === 1'b1) begin
                checks++;
                if (ma_a !== 8'(n) || md_a !== rom_val(8'(n))) begin
                    errors++;
                    $display("FAIL restart_write %0d: addr=%h data=%h, need %h %h", n, ma_a, md_a, 8'(n), rom_val(8'(n)));
                end
                n++;
            end
        end
        checks++;
        if (n !== 256 || dcyc !== 257) begin
            errors++;
            $display("FAIL restart_total: writes=%0d done_cycle=%0d, need 256 257", n, dcyc);
        end
    endtask

    task automatic test_stall();
        int n = 0;
        int stalled = 0;
        int dcyc = -1;
        rdy_a = 1'b1;
        reset_a();
        for (int cyc = 1; cyc <= 300; cyc++) begin
            @(negedge clk);
            if (done_a === 1'b1) begin
                dcyc = cyc;
                break;
            end
            if (we_a === 1'b1 && ma_a === 8'h05 && stalled < 3) begin
                rdy_a = 1'b0;
                stalled++;
                #1;
                checks++;
                if (md_a !== 32'h28820040 || ra_a !== 8'h05) begin
                    errors++;
                    $display("FAIL stall_hold %0d: data=%h rom_addr=%h, need 28820040 05", stalled, md_a, ra_a);
                end
            end else begin
                rdy_a = 1'b1;
            end
            if (we_a === 1'b1 && rdy_a === 1'b1) begin
                checks++;
                if (ma_a !== 8'(n) || md_a !== rom_val(8'(n))) begin
                    errors++;
                    $display("FAIL stall_write %0d: addr=%h data=%h, need %h %h", n, ma_a, md_a, 8'(n), rom_val(8'(n)));
                end
                if (n == 6) begin
                    checks++;
                    if (md_a !== 32'h0003fc03) begin
                        errors++;
                        $display("FAIL stall_after: data=%h, need 0003fc03", md_a);
                    end
                end
                n++;
            end
        end
        rdy_a = 1'b1;
        checks++;
        if (stalled !== 3 || n !== 256 || dcyc !== 260) begin
            errors++;
            $display("FAIL stall_total: stalls=%0d accepts=%0d done_cycle=%0d, need 3 256 260", stalled, n, dcyc);
        end
    endtask

    task automatic test_start_ignored();
        int n = 0;
        int dcyc = -1;
        rdy_a = 1'b1;
        reset_a();
        for (int cyc = 1; cyc <= 300; cyc++) begin
            @(negedge clk);
            st_a = (we_a === 1'b1 && ma_a === 8'd10);
            if (done_a === 1'b1) begin
                dcyc = cyc;
                break;
            end
            if (we_a === 1'b1) begin
                checks++;
                if (ma_a !== 8'(n) || md_a !== rom_val(8'(n))) begin
                    errors++;
                    $display("FAIL ignore_write %0d: addr=%h data=%h, need %h %h", n, ma_a, md_a, 8'(n), rom_val(8'(n)));
                end
                n++;
            end
        end
        st_a = 1'b0;
        checks++;
        if (n !== 256 || dcyc !== 257) begin
            errors++;
            $display("FAIL ignore_total: writes=%0d done_cycle=%0d, need 256 257", n, dcyc);
        end
    endtask

    task automatic test_reset_midcopy();
        int hit = 0;
        rdy_a = 1'b1;
        reset_a();
        for (int cyc = 1; cyc <= 100; cyc++) begin
            @(negedge clk);
            if (we_a === 1'b1 && ma_a === 8'h20) begin
                hit = 1;
                break;
            end
        end
        checks++;
        if (hit !== 1) begin
            errors++;
            $display("FAIL midreset_reach: reached k=20 %0d, need 1", hit);
        end
        rst_a = 1'b1;
        @(negedge clk);
        checks++;
        if (we_a !== 1'b0 || ma_a !== 8'h00 || cr_a !== 1'b1 || done_a !== 1'b0 || busy_a !== 1'b1 || ra_a !== 8'h00) begin
            errors++;
            $display("FAIL midreset_values: we=%b addr=%h cpu_reset=%b done=%b busy=%b rom_addr=%h, need 0 00 1 0 1 00",
                     we_a, ma_a, cr_a, done_a, busy_a, ra_a);
        end
        rst_a = 1'b0;
        @(negedge clk);
        checks++;
        if (we_a !== 1'b1 || ma_a !== 8'h00 || md_a !== 32'h00000001) begin
            errors++;
            $display("FAIL midreset_restart: we=%b addr=%h data=%h, need 1 00 00000001", we_a, ma_a, md_a);
        end
    endtask

    task automatic test_short_image();
        int n = 0;
        int dcyc = -1;
        logic [7:0]  la = 8'hff;
        logic [31:0] ld = 32'hffffffff;
        rst_b = 1'b1;
        rdy_b = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst_b = 1'b0;
        for (int cyc = 1; cyc <= 100; cyc++) begin
            @(negedge clk);
            if (done_b === 1'b1) begin
                dcyc = cyc;
                break;
            end
            if (we_b === 1'b1) begin
                checks++;
                if (ma_b !== 8'(n) || md_b !== rom_val(8'(n)) || ma_b >= 8'h32) begin
                    errors++;
                    $display("FAIL short_write %0d: addr=%h data=%h, need %h %h", n, ma_b, md_b, 8'(n), rom_val(8'(n)));
                end
                la = ma_b;
                ld = md_b;
                n++;
            end
        end
        checks++;
        if (n !== 50 || dcyc !== 51 || la !== 8'h31 || ld !== 32'h00000001) begin
            errors++;
            $display("FAIL short_total: writes=%0d done_cycle=%0d last_addr=%h last_data=%h, need 50 51 31 00000001",
                     n, dcyc, la, ld);
        end
    endtask

    task automatic test_manual_start();
        rst_c = 1'b1;
        st_c = 1'b1;
        rdy_c = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst_c = 1'b0;
        st_c = 1'b0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            checks++;
            if (cr_c !== 1'b1 || busy_c !== 1'b0 || we_c !== 1'b0 || done_c !== 1'b0) begin
                errors++;
                $display("FAIL manual_idle cycle %0d: cpu_reset=%b busy=%b we=%b done=%b, need 1 0 0 0",
                         cyc, cr_c, busy_c, we_c, done_c);
            end
            @(negedge clk);
        end
        st_c = 1'b1;
        @(negedge clk);
        st_c = 1'b0;
        checks++;
        if (busy_c !== 1'b1 || we_c !== 1'b0 || cr_c !== 1'b1 || ra_c !== 8'h00) begin
            errors++;
            $display("FAIL manual_prime: busy=%b we=%b cpu_reset=%b rom_addr=%h, need 1 0 1 00", busy_c, we_c, cr_c, ra_c);
        end
        @(negedge clk);
        checks++;
        if (we_c !== 1'b1 || ma_c !== 8'h00 || md_c !== 32'h00000001) begin
            errors++;
            $display("FAIL manual_first: we=%b addr=%h data=%h, need 1 00 00000001", we_c, ma_c, md_c);
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_full_copy();
        test_done_restart();
        test_stall();
        test_start_ignored();
        test_reset_midcopy();
        test_short_image();
        test_manual_start();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/rom_loader.md
# rom_loader

Boot-time copy engine that sequences the registered-output instruction ROM (1-cycle read latency, 8-bit address, 32-bit word) into the CPU's writable instruction memory. It holds the CPU in reset while the copy runs and releases it when the last word is accepted. It sits between the ROM, the instruction-memory write port and the CPU reset input. A `start` pulse reloads memory at runtime.

## Interface
- `ADDR_WIDTH`, 8: ROM and instruction-memory address width.
- `DATA_WIDTH`, 32: instruction word width.
- `LOAD_COUNT`, 256: number of words copied, from address 0 to LOAD_COUNT-1. Range 1..2^ADDR_WIDTH.
- `AUTO_START`, 1: 1 = the copy begins when reset is released; 0 = the block waits for `start`.
- `clk` in 1: the only clock; all state changes on its rising edge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: single-cycle request to (re)load.
- `rom_addr` out ADDR_WIDTH: address to the ROM. Combinational.
- `rom_data` in DATA_WIDTH: ROM output, registered inside the ROM. Holds ROM[a] in the cycle after `rom_addr` = a was sampled.
- `mem_we` out 1: write request to the instruction memory.
- `mem_addr` out ADDR_WIDTH: write address.
- `mem_data` out DATA_WIDTH: write data. Combinational pass-through of `rom_data`.
- `mem_ready` in 1: the memory accepts the write this cycle.
- `cpu_reset` out 1: holds the CPU in reset while high.
- `busy` out 1: a copy is in progress.
- `done` out 1: memory holds a valid image.

## Operation
- States and outputs:
  - IDLE: `cpu_reset`=1, `busy`=0, `done`=0, `mem_we`=0.
  - PRIME: `cpu_reset`=1, `busy`=1, `mem_we`=0, `rom_addr`=0.
  - COPY: `cpu_reset`=1, `busy`=1, `mem_we`=1.
  - DONE: `cpu_reset`=0, `busy`=0, `done`=1, `mem_we`=0.
- Transitions:
  - Reset goes to PRIME if AUTO_START=1, else to IDLE.
  - IDLE goes to PRIME on `start`.
  - PRIME goes to COPY after one cycle unconditionally.
  - In COPY, write index k starts at 0. The accept condition is `mem_we` & `mem_ready`. On accept, k increments.
  - COPY goes to DONE on accept of k = LOAD_COUNT-1.
  - DONE goes to PRIME on `start`.
- COPY outputs:
  - `mem_addr` = k (registered).
  - `mem_data` = `rom_data`.
  - `rom_addr` = k+1 when `mem_ready` is high, else k. The counter is ADDR_WIDTH bits and wraps; the wrapped value on the final accept is don't-care.
  - Because the ROM re-reads the same address every cycle, `rom_data` = ROM[k] is always valid while k is stalled.
- `rom_addr` in IDLE and DONE is 0 (don't-care).
- `mem_data` is don't-care whenever `mem_we`=0.
- `start` is ignored in PRIME and COPY. `start` coincident with `reset` is ignored.
- A stall of any length in COPY must hold `mem_we`=1 and keep `mem_addr` and `mem_data` stable. No word may be skipped or duplicated.
- Reset in any state, mid-copy included, aborts the copy on that edge:
  - k returns to 0.
  - No further write is issued.
  - Memory contents are not restored; the partial image is overwritten by the next copy.

## Timing
- Reset values: `mem_we`=0, `mem_addr`=0, `cpu_reset`=1, `done`=0, `busy`=AUTO_START, `rom_addr`=0.
- Throughput: one word per cycle while `mem_ready`=1. There are no bubbles between words.
- With AUTO_START=1 and `mem_ready` tied high, numbering the first cycle after reset deasserts as cycle 0:
  - Cycle 0: PRIME.
  - Cycles 1..LOAD_COUNT: COPY, writing word k in cycle k+1.
  - Cycle LOAD_COUNT+1: DONE, with `cpu_reset`=0 and `done`=1.
- A `start` sampled in DONE gives PRIME on the next cycle. `cpu_reset` and `busy` rise and `done` falls in that same cycle.
- Every stall cycle adds exactly one cycle to the schedule.

## Test plan
- **Full copy, auto start.** Defaults, `mem_ready`=1.
  - Expect 256 consecutive writes, `mem_addr` 0x00..0xff.
  - Spot-check data: addr 0x02 = 0x20000040, 0x0d = 0x20820381, 0x32 = 0x00000000.
  - `done` and `cpu_reset`=0 from cycle 257.
- **Stall.** Drop `mem_ready` for 3 cycles while k = 5.
  - `mem_we`=1, `mem_addr`=5 and `mem_data`=0x28820040 held all 3 cycles.
  - Next write is addr 6 = 0x0003fc03; exactly 256 accepts in total.
- **Short image.** LOAD_COUNT=0x32.
  - Last write is addr 0x31 = 0x00000001.
  - DONE at cycle 51; no write to 0x32 or above.
- **Manual start.** AUTO_START=0.
  - After reset: IDLE, `cpu_reset`=1, `busy`=0, no `mem_we` for 20 cycles.
  - Pulse `start`: PRIME next cycle, first write addr 0 = 0x00000001.
- **Start handling.**
  - A `start` pulsed at k = 10 is ignored: the copy completes normally.
  - A `start` pulsed in DONE gives `cpu_reset`=1 and `done`=0 next cycle, then a full reload from addr 0.
- **Reset mid-copy.** Assert `reset` at k = 0x20.
  - Next cycle: all outputs at their reset values.
  - After release: PRIME, then writes restart at addr 0.
